// File: rtl/mux_pkg.sv
// Shared types and constants for the N:1 pipelined selector.
// Holds the skid-buffer occupancy states and the out-of-range fill value.
package mux_pkg;

  localparam int MAX_N     = 16;
  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } mux_state_e;

  // Data presented for a select index that names no input.
  function automatic logic [MAX_WIDTH-1:0] oor_fill();
    return '0;
  endfunction

endpackage

// File: rtl/mux_nto1_comb.sv
// Purely combinational N:1 selector with out-of-range select detection.
// Produces zero data and err = 1 when select names no input.
module mux_nto1_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] inputs,
  input  logic [SELW-1:0]    select,
  output logic [WIDTH-1:0]   data,
  output logic               err
);

  always_comb begin
    data = WIDTH'(oor_fill());
    err  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (select == SELW'(k)) begin
        data = inputs[k*WIDTH +: WIDTH];
        err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_pipe.sv
// N:1 selector feeding a two-entry skid buffer with valid/ready on both sides.
// in_ready comes from a register, so no combinational path runs through the block.
module mux_nto1_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] inputs,
  input  logic [SELW-1:0]    select,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   result,
  output logic               err,
  output logic               out_valid,
  input  logic               out_ready
);

  mux_state_e       state_q, state_d;
  logic             in_ready_d;
  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic [WIDTH-1:0] main_data, skid_data;
  logic             main_err, skid_err;
  logic             accept, consume;
  logic             load_main, load_skid, move_skid;

  mux_nto1_comb #(
    .WIDTH (WIDTH),
    .N     (N),
    .SELW  (SELW)
  ) u_sel (
    .inputs (inputs),
    .select (select),
    .data   (sel_data),
    .err    (sel_err)
  );

  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  assign out_valid = (state_q != EMPTY);
  assign result    = main_data;
  assign err       = main_err;

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (accept && consume) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (consume) begin
          state_d   = ONE;
          move_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops everything, including a beat offered this cycle.
    if (flush) begin
      state_d   = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      in_ready <= in_ready_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= '0;
      main_err  <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      if (load_main) begin
        main_data <= sel_data;
        main_err  <= sel_err;
      end else if (move_skid) begin
        main_data <= skid_data;
        main_err  <= skid_err;
      end
      if (load_skid) begin
        skid_data <= sel_data;
        skid_err  <= sel_err;
      end
    end
  end

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Scoreboard bench for mux_nto1_pipe: an N=4 instance for streaming, backpressure,
// flush and async reset, and an N=3 instance for out-of-range selects.
module tb_mux_nto1_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [127:0] inputs4 = '0;
  logic [1:0]   sel4 = '0;
  logic         valid4 = 1'b0, flush4 = 1'b0, ordy4 = 1'b1;
  logic         ready4, err4, ovalid4;
  logic [31:0]  result4;

  logic [95:0]  inputs3 = '0;
  logic [1:0]   sel3 = '0;
  logic         valid3 = 1'b0, flush3 = 1'b0, ordy3 = 1'b1;
  logic         ready3, err3, ovalid3;
  logic [31:0]  result3;

  logic [32:0]  exp4[$];
  logic [32:0]  exp3[$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mux_nto1_pipe #(.WIDTH(32), .N(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .inputs    (inputs4),
    .select    (sel4),
    .in_valid  (valid4),
    .in_ready  (ready4),
    .flush     (flush4),
    .result    (result4),
    .err       (err4),
    .out_valid (ovalid4),
    .out_ready (ordy4)
  );

  mux_nto1_pipe #(.WIDTH(32), .N(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .inputs    (inputs3),
    .select    (sel3),
    .in_valid  (valid3),
    .in_ready  (ready3),
    .flush     (flush3),
    .result    (result3),
    .err       (err3),
    .out_valid (ovalid3),
    .out_ready (ordy3)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Offer one beat, hold it until accepted, and record what it must produce.
  task automatic applyStimulus(input int unit, input logic [1:0] sel, input logic [32:0] expv);
    int  waitCycles = 0;
    bit  done = 1'b0;
    if (unit == 0) begin sel4 = sel; valid4 = 1'b1; end
    else           begin sel3 = sel; valid3 = 1'b1; end
    while (!done) begin
      @(negedge clk);
      if ((unit == 0) ? ready4 : ready3) begin
        if (unit == 0) exp4.push_back(expv);
        else           exp3.push_back(expv);
        done = 1'b1;
      end else if (waitCycles++ > 50) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL accept timeout unit %0d: in_ready stuck at 0, expected 1", unit);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (unit == 0) valid4 = 1'b0;
    else           valid3 = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((exp4.size() != 0 || exp3.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput(name, 64'(exp4.size() + exp3.size()), 64'd0);
  endtask

  // Monitor: every delivered beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ovalid4 && ordy4) begin
        if (exp4.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL dut4 unexpected beat: got 0x%0h, expected none", {err4, result4});
        end else begin
          checkOutput("dut4 beat", 64'({err4, result4}), 64'(exp4.pop_front()));
        end
      end
      if (ovalid3 && ordy3) begin
        if (exp3.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL dut3 unexpected beat: got 0x%0h, expected none", {err3, result3});
        end else begin
          checkOutput("dut3 beat", 64'({err3, result3}), 64'(exp3.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exhausted, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    inputs4 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    inputs3 = {32'hCCCC_2222, 32'hBBBB_1111, 32'hAAAA_0000};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("reset in_ready",  64'(ready4),  64'd1);
    checkOutput("reset out_valid", 64'(ovalid4), 64'd0);
    checkOutput("reset result",    64'(result4), 64'd0);
    checkOutput("reset err",       64'(err4),    64'd0);
    checkOutput("reset dut3 in_ready", 64'(ready3), 64'd1);

    // Streaming with one-cycle latency.
    ordy4 = 1'b1;
    applyStimulus(0, 2'd0, {1'b0, 32'h1111_1111});
    checkOutput("latency", 64'({ovalid4, result4}), {31'd0, 1'b1, 32'h1111_1111});
    applyStimulus(0, 2'd3, {1'b0, 32'h4444_4444});
    checkOutput("stream valid", 64'(ovalid4), 64'd1);
    applyStimulus(0, 2'd2, {1'b0, 32'h3333_3333});
    checkOutput("stream valid", 64'(ovalid4), 64'd1);
    applyStimulus(0, 2'd1, {1'b0, 32'h2222_2222});
    waitDrain("stream drain");

    // Backpressure: A and B fill the buffer, C waits.
    ordy4 = 1'b0;
    applyStimulus(0, 2'd1, {1'b0, 32'h2222_2222});
    applyStimulus(0, 2'd2, {1'b0, 32'h3333_3333});
    fork
      applyStimulus(0, 2'd3, {1'b0, 32'h4444_4444});
      begin
        @(negedge clk);
        checkOutput("bp in_ready", 64'(ready4), 64'd0);
        checkOutput("bp hold head", 64'({ovalid4, err4, result4}), {30'd0, 2'b10, 32'h2222_2222});
        @(negedge clk);
        checkOutput("bp hold stable", 64'({ovalid4, err4, result4}), {30'd0, 2'b10, 32'h2222_2222});
        @(posedge clk);
        #1 ordy4 = 1'b1;
      end
    join
    waitDrain("bp drain");

    // Out-of-range select on the N=3 instance.
    ordy3 = 1'b1;
    applyStimulus(1, 2'd3, {1'b1, 32'h0});
    checkOutput("oor err", 64'({ovalid3, err3, result3}), {30'd0, 2'b11, 32'h0});
    applyStimulus(1, 2'd1, {1'b0, 32'hBBBB_1111});
    checkOutput("after oor err", 64'(err3), 64'd0);
    applyStimulus(1, 2'd2, {1'b0, 32'hCCCC_2222});
    waitDrain("oor drain");

    // Flush while full, with a beat offered in the same cycle.
    ordy4 = 1'b0;
    applyStimulus(0, 2'd0, {1'b0, 32'h1111_1111});
    applyStimulus(0, 2'd1, {1'b0, 32'h2222_2222});
    flush4 = 1'b1;
    valid4 = 1'b1;
    sel4   = 2'd2;
    @(posedge clk);
    #1;
    flush4 = 1'b0;
    valid4 = 1'b0;
    exp4.delete();
    checkOutput("flush out_valid", 64'(ovalid4), 64'd0);
    checkOutput("flush in_ready",  64'(ready4),  64'd1);
    ordy4 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    applyStimulus(0, 2'd3, {1'b0, 32'h4444_4444});
    waitDrain("post flush drain");

    // Asynchronous reset between edges while full.
    ordy4 = 1'b0;
    applyStimulus(0, 2'd2, {1'b0, 32'h3333_3333});
    applyStimulus(0, 2'd3, {1'b0, 32'h4444_4444});
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async rst out_valid", 64'(ovalid4), 64'd0);
    checkOutput("async rst in_ready",  64'(ready4),  64'd1);
    checkOutput("async rst result",    64'(result4), 64'd0);
    exp4.delete();
    ordy4 = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(0, 2'd1, {1'b0, 32'h2222_2222});
    waitDrain("post reset drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
